// File: rtl/register10bit_pkg.sv
// Shared definitions for the 10-bit pipeline register: word width, parity bit position,
// the word type, and an even-parity helper function.
package register10bit_pkg;

    localparam int REG_WIDTH  = 10;
    localparam int PARITY_BIT = REG_WIDTH - 1;

    typedef logic [REG_WIDTH-1:0] word_t;

    // Returns 1 when the word holds an even number of ones, i.e. its parity is valid.
    function automatic logic even_parity_ok(input word_t w);
        return ~^w;
    endfunction

endpackage

// File: rtl/register10bit_parity_even_check.sv
// Combinational even-parity check: ok=1 when the XOR of all word bits is 0.
// Only instantiated when PARITY_CHECK_EN is defined.
module parity_even_check
    import register10bit_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    output logic             ok
);

    logic [WIDTH-1:0] xor_chain;

    assign xor_chain[0] = word[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_xor
            assign xor_chain[gi] = xor_chain[gi-1] ^ word[gi];
        end
    endgenerate

    assign ok = ~xor_chain[WIDTH-1];

endmodule

// File: rtl/register10bit.sv
// Single-stage 10-bit pipeline register (9 data bits + even-parity MSB) with an optional
// registered parity_ok flag, built only when the PARITY_CHECK_EN macro is defined.
module register10bit
    import register10bit_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg_ins,
    output logic [WIDTH-1:0] reg_outs,
    output logic             parity_ok
);

    logic [WIDTH-1:0] reg_outs_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_outs_reg <= '0;
        end else begin
            reg_outs_reg <= reg_ins;
        end
    end

    assign reg_outs = reg_outs_reg;

`ifdef PARITY_CHECK_EN
    logic parity_ok_next;
    logic parity_ok_reg;

    parity_even_check #(
        .WIDTH (WIDTH)
    ) u_parity_even_check (
        .word (reg_ins),
        .ok   (parity_ok_next)
    );

    // Reset value 1: the all-zero word loaded into reg_outs has valid even parity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_ok_reg <= 1'b1;
        end else begin
            parity_ok_reg <= parity_ok_next;
        end
    end

    assign parity_ok = parity_ok_reg;
`else
    assign parity_ok = 1'b1;
`endif

endmodule

// File: tb/tb_register10bit.sv
// Self-checking bench for register10bit: directed scenarios plus a randomized stream
// compared against a one-cycle-delay reference model with popcount-based parity.
module tb_register10bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] reg_ins;
    logic [9:0] reg_outs;
    logic       parity_ok;

    int checks   = 0;
    int failures = 0;

    register10bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_ins   (reg_ins),
        .reg_outs  (reg_outs),
        .parity_ok (parity_ok)
    );

    always #5 clk = ~clk;

    // Reference parity: even number of ones is valid; without the feature the flag is constant 1.
    function automatic logic model_parity(input logic [9:0] w);
`ifdef PARITY_CHECK_EN
        return ($countones(w) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        reg_ins = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (reg_outs !== 10'h000) begin
                failures++;
                $display("FAIL reset_outs cycle=%0d got=%h exp=%h", i, reg_outs, 10'h000);
            end
            checks++;
            if (parity_ok !== 1'b1) begin
                failures++;
                $display("FAIL reset_parity cycle=%0d got=%b exp=1", i, parity_ok);
            end
            checks++;
            $display("reset cycle %0d: reg_outs=%h parity_ok=%b", i, reg_outs, parity_ok);
        end
    endtask

    task automatic test_single_capture();
        logic [9:0] vals [2];
        vals[0] = 10'h155;
        vals[1] = 10'h355;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            reg_ins = vals[i];
            tick();
            if (reg_outs !== vals[i]) begin
                failures++;
                $display("FAIL single_outs got=%h exp=%h", reg_outs, vals[i]);
            end
            checks++;
            if (parity_ok !== model_parity(vals[i])) begin
                failures++;
                $display("FAIL single_parity word=%h got=%b exp=%b", vals[i], parity_ok,
                         model_parity(vals[i]));
            end
            checks++;
            $display("single: in=%h reg_outs=%h parity_ok=%b", vals[i], reg_outs, parity_ok);
        end
    endtask

    task automatic test_sweep();
        int errs_before;
        errs_before = failures;
        rst_n = 1'b1;
        for (int v = 0; v < 1024; v++) begin
            logic [9:0] w;
            w = v[9:0];
            reg_ins = w;
            for (int c = 0; c < 2; c++) begin
                tick();
                if (reg_outs !== w) begin
                    failures++;
                    $display("FAIL sweep_outs word=%h got=%h exp=%h", w, reg_outs, w);
                end
                checks++;
                if (parity_ok !== model_parity(w)) begin
                    failures++;
                    $display("FAIL sweep_parity word=%h got=%b exp=%b", w, parity_ok, model_parity(w));
                end
                checks++;
            end
        end
        $display("sweep: 1024 words, new failures=%0d", failures - errs_before);
    endtask

    task automatic test_back_to_back();
        logic [9:0] seq [3];
        logic       exp_par [3];
        seq[0] = 10'h001; seq[1] = 10'h002; seq[2] = 10'h3FE;
        exp_par[0] = model_parity(seq[0]);
        exp_par[1] = model_parity(seq[1]);
        exp_par[2] = model_parity(seq[2]);
        rst_n = 1'b1;
        reg_ins = 10'h000;
        tick();
        for (int i = 0; i < 3; i++) begin
            logic [9:0] prev;
            prev = reg_outs;
            reg_ins = seq[i];
            // Before the edge the output must still hold the previous word.
            #2;
            if (reg_outs !== prev) begin
                failures++;
                $display("FAIL b2b_early idx=%0d got=%h exp=%h", i, reg_outs, prev);
            end
            checks++;
            tick();
            if (reg_outs !== seq[i]) begin
                failures++;
                $display("FAIL b2b_outs idx=%0d got=%h exp=%h", i, reg_outs, seq[i]);
            end
            checks++;
            if (parity_ok !== exp_par[i]) begin
                failures++;
                $display("FAIL b2b_parity idx=%0d got=%b exp=%b", i, parity_ok, exp_par[i]);
            end
            checks++;
            $display("b2b: in=%h reg_outs=%h parity_ok=%b", seq[i], reg_outs, parity_ok);
        end
    endtask

    task automatic test_mid_reset();
        rst_n   = 1'b1;
        reg_ins = 10'h2AA;
        tick();
        tick();
        if (reg_outs !== 10'h2AA) begin
            failures++;
            $display("FAIL midrst_pre got=%h exp=%h", reg_outs, 10'h2AA);
        end
        checks++;
        rst_n = 1'b0;
        tick();
        if (reg_outs !== 10'h000) begin
            failures++;
            $display("FAIL midrst_outs got=%h exp=%h", reg_outs, 10'h000);
        end
        checks++;
        if (parity_ok !== 1'b1) begin
            failures++;
            $display("FAIL midrst_parity got=%b exp=1", parity_ok);
        end
        checks++;
        $display("midrst: reset edge reg_outs=%h parity_ok=%b", reg_outs, parity_ok);
        rst_n = 1'b1;
        tick();
        if (reg_outs !== 10'h2AA) begin
            failures++;
            $display("FAIL midrst_resume got=%h exp=%h", reg_outs, 10'h2AA);
        end
        checks++;
        if (parity_ok !== model_parity(10'h2AA)) begin
            failures++;
            $display("FAIL midrst_resume_parity got=%b exp=%b", parity_ok, model_parity(10'h2AA));
        end
        checks++;
        $display("midrst: resume reg_outs=%h parity_ok=%b", reg_outs, parity_ok);
    endtask

    task automatic test_random();
        logic [9:0] exp_word;
        logic       exp_par;
        int         errs_before;
        errs_before = failures;
        for (int i = 0; i < 500; i++) begin
            logic [9:0] w;
            logic       r;
            w = 10'($urandom_range(0, 1023));
            r = ($urandom_range(0, 9) == 0);
            reg_ins = w;
            rst_n   = ~r;
            exp_word = r ? 10'h000 : w;
            exp_par  = r ? 1'b1 : model_parity(w);
            tick();
            if (reg_outs !== exp_word) begin
                failures++;
                $display("FAIL rand_outs i=%0d rst=%b in=%h got=%h exp=%h", i, r, w, reg_outs, exp_word);
            end
            checks++;
            if (parity_ok !== exp_par) begin
                failures++;
                $display("FAIL rand_parity i=%0d rst=%b in=%h got=%b exp=%b", i, r, w, parity_ok, exp_par);
            end
            checks++;
        end
        rst_n = 1'b1;
        $display("random: 500 cycles, new failures=%0d", failures - errs_before);
    endtask

    initial begin
        rst_n   = 1'b0;
        reg_ins = 10'h000;
        test_reset();
        test_single_capture();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
